// File: rtl/mcpu_pkg.sv
// Shared constants for the MCPU accumulator machine: opcode field values and
// controller state encodings. State values are fixed by the legacy design and
// must not be renumbered.
package mcpu_pkg;

    // Instruction byte: [7:6] opcode, [5:0] operand address.
    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    // Controller states. 100, 110 and 111 are never entered.
    localparam logic [2:0] ST_FETCH = 3'b000;
    localparam logic [2:0] ST_STA   = 3'b001;
    localparam logic [2:0] ST_ADD   = 3'b010;
    localparam logic [2:0] ST_NOR   = 3'b011;
    localparam logic [2:0] ST_SKIP  = 3'b101;

endpackage

// File: rtl/mcpu.sv
// Purpose: minimal 8-bit accumulator CPU (NOR/ADD/STA/JCC) on a shared async memory bus.
// Latency: 2 cycles per instruction; a taken JCC (carry clear) completes in 1 cycle.
// Backpressure: none; memory is assumed to answer within the low half of every clock.
// Ports: clk (state on rising edge, strobes during clk low), rst (async, active-low),
//        data (bidirectional bus, driven only in STA), adress (memory address),
//        oe / we (active-low read / write strobes, combinational from clk and state).
module mcpu
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] data,
    output logic [5:0] adress,
    output logic       oe,
    output logic       we
);

    logic [2:0] state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [5:0] adress_q, adress_d;
    logic [5:0] pc_q, pc_d;
    logic       in_sta;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        adress_d = adress_q;
        pc_d     = pc_q;
        if (state_q == ST_FETCH) begin
            // The operand field is loaded straight into the address register:
            // it is the data address for NOR/ADD/STA and the jump target for
            // a JCC with carry clear, which therefore fetches there next edge.
            pc_d     = adress_q + 6'd1;
            adress_d = data[5:0];
            case (data[7:6])
                OP_NOR:  state_d = ST_NOR;
                OP_ADD:  state_d = ST_ADD;
                OP_STA:  state_d = ST_STA;
                default: state_d = carry_q ? ST_SKIP : ST_FETCH;
            endcase
        end else begin
            // Every execute state returns to sequential fetch at PC.
            adress_d = pc_q;
            state_d  = ST_FETCH;
            case (state_q)
                ST_ADD:  {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data};
                ST_NOR:  acc_d = ~(acc_q | data);
                ST_SKIP: carry_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            acc_q    <= 8'h00;
            carry_q  <= 1'b0;
            adress_q <= 6'd0;
            pc_q     <= 6'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            adress_q <= adress_d;
            pc_q     <= pc_d;
        end
    end

    // Strobes are only asserted while clk is low so the address has settled
    // since the rising edge; STA selects write instead of read, so the two
    // strobes are mutually exclusive by construction.
    assign in_sta = (state_q == ST_STA);
    assign oe     = clk | ~rst | in_sta;
    assign we     = clk | ~rst | ~in_sta;
    assign data   = (in_sta && rst) ? acc_q : 8'hzz;
    assign adress = adress_q;

endmodule

// File: tb/tb_mcpu.sv
module tb_mcpu;

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    wire  [7:0] data;
    logic [5:0] adress;
    logic       oe;
    logic       we;

    mcpu dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .adress (adress),
        .oe     (oe),
        .we     (we)
    );

    always #50 clk = ~clk;

    // 64x8 asynchronous RAM with a short output hold after oe rises.
    logic [7:0] mem      [64];
    logic [7:0] init_img [64];
    logic       load_req = 1'b0;
    logic       ram_en   = 1'b0;
    int         we_cnt   = 0;
    logic       wr_oe    = 1'b0;
    int         ovl      = 0;

    assign data = ram_en ? mem[adress] : 8'hzz;

    always @(negedge oe) ram_en = 1'b1;
    always @(posedge oe) begin
        #5;
        ram_en = 1'b0;
    end

    always @(negedge we or posedge load_req) begin
        if (load_req) begin
            mem    = init_img;
            we_cnt = 0;
        end else begin
            mem[adress] = data;
            we_cnt      = we_cnt + 1;
            wr_oe       = oe;
        end
    end

    always @(oe or we) if (oe === 1'b0 && we === 1'b0) ovl = ovl + 1;

    // Instruction-level reference machine.
    logic [7:0] mdl_mem [64];
    logic [7:0] macc;
    logic       mc;
    logic [5:0] mpc;
    int         nsta;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_and_reset();
        rst = 1'b0;
        load_req = 1'b1;
        #1;
        load_req = 1'b0;
        mdl_mem = init_img;
        macc = 8'h00;
        mc   = 1'b0;
        mpc  = 6'd0;
        nsta = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Execute one instruction in the model, let the DUT run the same number
    // of cycles, then compare architectural state.
    task automatic step();
        logic [7:0] ins;
        logic [5:0] opd;
        logic [8:0] sum;
        int         ncyc;
        logic [5:0] nxt;
        logic       was_sta;
        ins     = mdl_mem[mpc];
        opd     = ins[5:0];
        ncyc    = 2;
        nxt     = mpc + 6'd1;
        was_sta = 1'b0;
        case (ins[7:6])
            2'b00: macc = ~(macc | mdl_mem[opd]);
            2'b01: begin
                sum  = macc + mdl_mem[opd];
                macc = sum[7:0];
                mc   = sum[8];
            end
            2'b10: begin
                mdl_mem[opd] = macc;
                nsta = nsta + 1;
                was_sta = 1'b1;
            end
            default: begin
                if (!mc) begin
                    ncyc = 1;
                    nxt  = opd;
                end else begin
                    mc = 1'b0;
                end
            end
        endcase
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        #1;
        mpc = nxt;
        chk("adress", adress, mpc);
        chk("acc", dut.acc_q, macc);
        chk("carry", dut.carry_q, mc);
        chk("we_pulses", we_cnt, nsta);
        if (was_sta) begin
            chk("sta_mem", mem[opd], macc);
            chk("sta_oe_high", wr_oe, 1'b1);
        end
    endtask

    logic [7:0] d_acc [14] = '{8'h0F, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h00,
                               8'h01, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
    logic       d_c   [14] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    logic [5:0] d_adr [14] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h24};

    initial begin
        // Power-on reset: outputs settle without any clock edge.
        #10;
        chk("por_adress", adress, 6'd0);
        chk("por_oe", oe, 1'b1);
        chk("por_we", we, 1'b1);
        chk("por_acc", dut.acc_q, 8'h00);

        // Counting loop ending in a self-jump halt.
        for (int i = 0; i < 64; i++) init_img[i] = 8'h00;
        init_img[61] = 8'h00; init_img[62] = 8'hFF; init_img[63] = 8'h01;
        init_img[0] = 8'h3E; init_img[1] = 8'h46; init_img[2] = 8'h7F; init_img[3] = 8'hC2;
        init_img[4] = 8'hC4; init_img[5] = 8'hC4; init_img[6] = 8'hFC; init_img[7] = 8'h00;
        load_and_reset();
        step();
        chk("loop_nor", dut.acc_q, 8'h00);
        step();
        chk("loop_add6", dut.acc_q, 8'hFC);
        for (int i = 0; i < 7; i++) step();
        chk("loop_wrap_acc", dut.acc_q, 8'h00);
        chk("loop_wrap_c", dut.carry_q, 1'b1);
        step();
        chk("loop_fall_adr", adress, 6'd4);
        chk("loop_fall_c", dut.carry_q, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("halt_adress", adress, 6'd4);
        end

        // NOR / ADD carry / JCC timing program.
        for (int i = 0; i < 64; i++) init_img[i] = 8'h00;
        init_img[0] = 8'h28; init_img[1] = 8'h29; init_img[2] = 8'h2A; init_img[3] = 8'h2B;
        init_img[4] = 8'h2C; init_img[5] = 8'h6D; init_img[6] = 8'h2E; init_img[7] = 8'h6F;
        init_img[8] = 8'hE0;
        init_img[6'h20] = 8'h30; init_img[6'h21] = 8'h71; init_img[6'h22] = 8'h71;
        init_img[6'h23] = 8'hCA; init_img[6'h24] = 8'hE4;
        init_img[6'h28] = 8'hF0; init_img[6'h29] = 8'hF0; init_img[6'h2A] = 8'h00;
        init_img[6'h2B] = 8'h7F; init_img[6'h2C] = 8'h7F; init_img[6'h2D] = 8'h80;
        init_img[6'h2E] = 8'hFF; init_img[6'h2F] = 8'h01; init_img[6'h30] = 8'hFF;
        init_img[6'h31] = 8'hFF;
        load_and_reset();
        for (int i = 0; i < 14; i++) begin
            step();
            chk("dir_acc", dut.acc_q, d_acc[i]);
            chk("dir_c", dut.carry_q, d_c[i]);
            chk("dir_adr", adress, d_adr[i]);
        end

        // STA aborted by reset, then completed.
        for (int i = 0; i < 64; i++) init_img[i] = 8'h00;
        init_img[0] = 8'h3D; init_img[1] = 8'hB8; init_img[2] = 8'hC2;
        init_img[61] = 8'hA5; init_img[56] = 8'h33;
        load_and_reset();
        step();
        chk("sta_pre_acc", dut.acc_q, 8'h5A);
        @(posedge clk);
        #10;
        rst = 1'b0;
        @(negedge clk);
        #5;
        chk("abort_we", we, 1'b1);
        chk("abort_oe", oe, 1'b1);
        chk("abort_adr", adress, 6'd0);
        chk("abort_mem", mem[56], 8'h33);
        chk("abort_pulses", we_cnt, 0);
        rst = 1'b1;
        macc = 8'h00; mc = 1'b0; mpc = 6'd0;
        step();
        step();
        chk("sta_mem56", mem[56], 8'h5A);
        chk("sta_one_pulse", we_cnt, 1);

        // Random programs against the reference machine.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) init_img[i] = 8'($urandom_range(0, 255));
            load_and_reset();
            for (int n = 0; n < 150; n++) step();
        end

        // Reset asserted mid-cycle with clk low: immediate effect.
        @(negedge clk);
        #20;
        rst = 1'b0;
        #1;
        chk("mid_adress", adress, 6'd0);
        chk("mid_oe", oe, 1'b1);
        chk("mid_we", we, 1'b1);
        chk("mid_acc", dut.acc_q, 8'h00);
        chk("mid_carry", dut.carry_q, 1'b0);
        chk("strobe_overlap", ovl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
